mc_control_fsm: RTL and testbench

- Multicycle control unit for the 32-bit ARM-subset CPU.
- Sits directly upstream of the conditional-logic stage: it decodes the latched instruction fields, steps a per-instruction Moore state machine, and produces the datapath mux selects and ALU control.
- Its raw write requests (PCS, RegW, MemW, FlagW) feed the conditional-logic stage, which gates them with the condition result.
- It also produces the unconditional NextPC and IRWrite strobes.

---
 rtl/mc_control_fsm.sv | 182 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle ARM-subset control FSM driving datapath selects and write requests
// Optional MC_CTRL_ILLEGAL_TRAP_EN: Op=11 traps into HALT and raises the sticky illegal flag.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    HALT     = 4'd10
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cmd;
  logic       s_bit;
  logic       branch;
  logic       alu_dec;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default: state_d = HALT;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      MEMADR:             state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:            state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      HALT:               state_d = HALT;
`endif
      default:            state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode; reset forces every strobe and select low regardless of state
  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    branch     = 1'b0;
    alu_dec    = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    if (!reset) begin
      ImmSrc = Op;
      RegSrc = {Op == 2'b01, Op == 2'b10};
      case (state_q)
        FETCH: begin
          IRWrite   = 1'b1;
          NextPC    = 1'b1;
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        DECODE: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        MEMADR:   ALUSrcB = 2'b01;
        MEMREAD:  AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc = 2'b01;
          RegW      = 1'b1;
        end
        MEMWRITE: begin
          AdrSrc = 1'b1;
          MemW   = 1'b1;
        end
        EXECUTER: alu_dec = 1'b1;
        EXECUTEI: begin
          ALUSrcB = 2'b01;
          alu_dec = 1'b1;
        end
        ALUWB: begin
          alu_dec = 1'b1;
          RegW    = (cmd != 4'b1010);
        end
        BRANCH: begin
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          branch    = 1'b1;
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        HALT:     illegal = 1'b1;
`endif
        default: ;
      endcase
      // CMP shares SUB; unknown commands fall back to ADD without touching flags
      if (alu_dec) begin
        case (cmd)
          4'b0100: begin
            ALUControl = 2'b00;
            FlagW      = {s_bit, s_bit};
          end
          4'b0010, 4'b1010: begin
            ALUControl = 2'b01;
            FlagW      = {s_bit, s_bit};
          end
          4'b0000: begin
            ALUControl = 2'b10;
            FlagW      = {s_bit, 1'b0};
          end
          4'b1100: begin
            ALUControl = 2'b11;
            FlagW      = {s_bit, 1'b0};
          end
          default: begin
            ALUControl = 2'b00;
            FlagW      = 2'b00;
          end
        endcase
      end
      PCS = branch | (RegW & (Rd == 4'hF));
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm against an instruction-level model
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, NextPC, AdrSrc, PCS, RegW, MemW;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic       illegal_w;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal_w)
`endif
  );

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  typedef struct packed {
    logic       ill;
    logic       irw;
    logic       npc;
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic [1:0] aluc;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
  } out_t;

  localparam logic [20:0] B_MEMW  = 21'h000001;
  localparam logic [20:0] B_REGW  = 21'h000002;
  localparam logic [20:0] B_PCS   = 21'h000004;
  localparam logic [20:0] B_FLAGW = 21'h000018;
  localparam logic [20:0] B_ALUC  = 21'h000060;
  localparam logic [20:0] B_RES   = 21'h001800;
  localparam logic [20:0] B_SRCB  = 21'h006000;
  localparam logic [20:0] B_ADR   = 21'h020000;
  localparam logic [20:0] B_NPC   = 21'h040000;
  localparam logic [20:0] B_IRW   = 21'h080000;
  localparam logic [20:0] B_ILL   = 21'h100000;
  localparam logic [20:0] B_STRB  = B_IRW | B_NPC | B_REGW | B_MEMW | B_PCS | B_FLAGW | B_ILL;

  logic [20:0] dut_vec;
  assign dut_vec = {illegal_w, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    ImmSrc, RegSrc, ALUControl, FlagW, PCS, RegW, MemW};

  logic [20:0] exp_q[$];
  out_t        mq[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Expected per-cycle outputs of one instruction, FETCH through its last cycle
  task automatic model_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    out_t       base, o;
    logic [3:0] cmd;
    logic       s;
    logic [1:0] aluc, flagw;
    mq.delete();
    base        = '0;
    base.imm    = op;
    base.regsrc = {op == 2'b01, op == 2'b10};
    o = base; o.irw = 1'b1; o.npc = 1'b1; o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
    mq.push_back(o);
    o = base; o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
    mq.push_back(o);
    cmd = f[4:1];
    s   = f[0];
    case (cmd)
      4'b0100:          begin aluc = 2'b00; flagw = {s, s};    end
      4'b0010, 4'b1010: begin aluc = 2'b01; flagw = {s, s};    end
      4'b0000:          begin aluc = 2'b10; flagw = {s, 1'b0}; end
      4'b1100:          begin aluc = 2'b11; flagw = {s, 1'b0}; end
      default:          begin aluc = 2'b00; flagw = 2'b00;     end
    endcase
    if (op == 2'b00) begin
      o = base; o.srcb = f[5] ? 2'b01 : 2'b00; o.aluc = aluc; o.flagw = flagw;
      mq.push_back(o);
      o = base; o.aluc = aluc; o.flagw = flagw; o.regw = (cmd != 4'b1010);
      o.pcs = o.regw && (rd == 4'hF);
      mq.push_back(o);
    end else if (op == 2'b01) begin
      o = base; o.srcb = 2'b01;
      mq.push_back(o);
      if (s) begin
        o = base; o.adr = 1'b1;
        mq.push_back(o);
        o = base; o.res = 2'b01; o.regw = 1'b1; o.pcs = (rd == 4'hF);
        mq.push_back(o);
      end else begin
        o = base; o.adr = 1'b1; o.memw = 1'b1;
        mq.push_back(o);
      end
    end else if (op == 2'b10) begin
      o = base; o.srcb = 2'b01; o.res = 2'b10; o.pcs = 1'b1;
      mq.push_back(o);
    end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      o = base; o.ill = 1'b1;
      repeat (4) mq.push_back(o);
`endif
    end
  endtask

  task automatic pin(input string name, input logic [20:0] mask, input logic [20:0] want);
    n_cmp++;
    if ((dut_vec & mask) !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (mask %h) t=%0t", name, dut_vec & mask, want, mask, $time);
    end
  endtask

  task automatic do_reset(input int k);
    reset = 1'b1;
    repeat (k) exp_q.push_back(21'h0);
    repeat (k) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input int n,
                           input int c1, input logic [20:0] m1, input logic [20:0] v1,
                           input int c2, input logic [20:0] m2, input logic [20:0] v2,
                           input bit chk_fetch);
    Op = op; Funct = f; Rd = rd;
    model_instr(op, f, rd);
    foreach (mq[i]) exp_q.push_back(mq[i]);
    for (int c = 0; c < n; c++) begin
      #2;
      if (m1 != 21'h0 && c == c1) pin({name, "_a"}, m1, v1);
      if (m2 != 21'h0 && c == c2) pin({name, "_b"}, m2, v2);
      @(posedge clk);
      #1;
    end
    if (chk_fetch) begin
      #1;
      pin({name, "_latency"}, B_IRW | B_NPC, B_IRW | B_NPC);
    end
  endtask

  always @(negedge clk) begin
    logic [20:0] want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_cmp++;
      if (dut_vec !== want) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: got %h want %h", $time, dut_vec, want);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'h0; Rd = 4'h0;
    @(posedge clk);
    #1;
    do_reset(3);
    #1;
    pin("first_fetch", B_IRW | B_NPC, B_IRW | B_NPC);

    run_instr("add_s",   2'b00, 6'b001001, 4'd1,  4, 2, B_ALUC | B_FLAGW, 21'h18,
              3, B_REGW | B_PCS, 21'h2, 1);
    run_instr("add_r15", 2'b00, 6'b001000, 4'hF,  4, 3, B_REGW | B_PCS | B_FLAGW, 21'h6,
              0, 21'h0, 21'h0, 1);
    run_instr("cmp",     2'b00, 6'b010101, 4'd3,  4, 2, B_ALUC | B_FLAGW, 21'h38,
              3, B_REGW, 21'h0, 1);
    run_instr("orr_imm", 2'b00, 6'b111001, 4'd2,  4, 2, B_SRCB | B_ALUC | B_FLAGW, 21'h2070,
              0, 21'h0, 21'h0, 1);
    run_instr("and_reg", 2'b00, 6'b000000, 4'd4,  4, 2, B_ALUC | B_FLAGW, 21'h40,
              0, 21'h0, 21'h0, 1);
    run_instr("eor_unk", 2'b00, 6'b000011, 4'd4,  4, 2, B_ALUC | B_FLAGW, 21'h0,
              3, B_REGW, 21'h2, 1);
    run_instr("ldr",     2'b01, 6'b011001, 4'd5,  5, 3, B_ADR, 21'h20000,
              4, B_RES | B_REGW | B_PCS, 21'h802, 1);
    run_instr("str",     2'b01, 6'b011000, 4'd6,  4, 3, B_ADR | B_MEMW, 21'h20001,
              0, 21'h0, 21'h0, 1);
    run_instr("ldr_pc",  2'b01, 6'b011001, 4'hF,  5, 4, B_REGW | B_PCS, 21'h6,
              0, 21'h0, 21'h0, 1);
    run_instr("branch",  2'b10, 6'b100000, 4'd0,  3, 2, B_PCS | B_SRCB | B_RES, 21'h3004,
              0, 21'h0, 21'h0, 1);

    // abort an LDR in its writeback cycle
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd7;
    model_instr(Op, Funct, Rd);
    for (int i = 0; i < 4; i++) exp_q.push_back(mq[i]);
    repeat (4) @(posedge clk);
    #1;
    do_reset(1);
    #1;
    pin("abort_fetch", B_STRB, B_IRW | B_NPC);
    run_instr("add_after", 2'b00, 6'b001001, 4'd1, 4, 0, 21'h0, 21'h0, 0, 21'h0, 21'h0, 1);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    run_instr("halt", 2'b11, 6'b111111, 4'hF, 6, 5, B_STRB, B_ILL,
              2, B_STRB, B_ILL, 0);
    do_reset(2);
    #1;
    pin("halt_exit", B_STRB, B_IRW | B_NPC);
`else
    run_instr("undef_op", 2'b11, 6'b111111, 4'hF, 2, 1, B_STRB, 21'h0,
              0, 21'h0, 21'h0, 1);
`endif
    run_instr("final_b", 2'b10, 6'b100000, 4'd0, 3, 0, 21'h0, 21'h0, 0, 21'h0, 21'h0, 1);

    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
